// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port DataMemory arbiter: FSM states and requester ids.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT_RD = 2'd2,
    ARB_WAIT_WR = 2'd3
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational two-way picker. MEM_ARB_RR_EN selects round-robin on ties
// (pointer = preferred port); otherwise the D-cache always wins a tie.
module arb_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       pointer,
  output logic       winner,
  output logic       any
);

  assign any = |req;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    if (&req) begin
      winner = pointer;
    end else begin
      winner = req[PORT_D] ? PORT_D : PORT_I;
    end
  end
`else
  logic pointer_unused;
  assign pointer_unused = pointer;
  assign winner = req[PORT_D] ? PORT_D : PORT_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide DataMemory port between the I-cache (port 0) and D-cache (port 1).
// Tie policy is round-robin when MEM_ARB_RR_EN is defined, fixed D-cache priority otherwise.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int ADDR_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   p0_req,
  input  logic                   p0_rw,
  input  logic [ADDR_W-1:0]      p0_addr,
  input  logic [LINE_SIZE*8-1:0] p0_din,
  output logic                   p0_done,
  output logic [LINE_SIZE*8-1:0] p0_dout,
  input  logic                   p1_req,
  input  logic                   p1_rw,
  input  logic [ADDR_W-1:0]      p1_addr,
  input  logic [LINE_SIZE*8-1:0] p1_din,
  output logic                   p1_done,
  output logic [LINE_SIZE*8-1:0] p1_dout,
  output logic                   mem_input_valid,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [LINE_SIZE*8-1:0] mem_din,
  input  logic                   mem_ready,
  input  logic                   mem_output_valid,
  input  logic [LINE_SIZE*8-1:0] mem_dout,
  output logic                   grant_id
);

  localparam int LW = LINE_SIZE * 8;

  arb_state_t        state, state_nxt;
  logic              grant_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LW-1:0]     din_q;
  logic              winner, any, pointer, take, done, fill;

  assign take = (state == ARB_IDLE) && any && mem_ready;

`ifdef MEM_ARB_RR_EN
  // Holds the complement of the preferred port, so the reset value 0 favours the D-cache
  // and each grant hands preference to the other port.
  logic ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (take) begin
      ptr_q <= winner;
    end
  end

  assign pointer = ~ptr_q;
`else
  assign pointer = 1'b0;
`endif

  arb_pick2 u_pick (
    .req     ({p1_req, p0_req}),
    .pointer (pointer),
    .winner  (winner),
    .any     (any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ARB_IDLE;
      grant_q <= PORT_I;
    end else begin
      state <= state_nxt;
      if (take) begin
        grant_q <= winner;
      end
    end
  end

  // Transaction latch: only meaningful while not IDLE, so it carries no reset.
  always_ff @(posedge clk) begin
    if (take) begin
      rw_q   <= (winner == PORT_D) ? p1_rw   : p0_rw;
      addr_q <= (winner == PORT_D) ? p1_addr : p0_addr;
      din_q  <= (winner == PORT_D) ? p1_din  : p0_din;
    end
  end

  always_comb begin
    state_nxt       = state;
    mem_input_valid = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    done            = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (take) begin
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mem_input_valid = 1'b1;
        mem_read        = ~rw_q;
        mem_write       = rw_q;
        state_nxt       = rw_q ? ARB_WAIT_WR : ARB_WAIT_RD;
      end
      ARB_WAIT_RD: begin
        mem_read = 1'b1;
        if (mem_output_valid) begin
          done      = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      ARB_WAIT_WR: begin
        mem_write = 1'b1;
        if (mem_ready) begin
          done      = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Completion is forwarded combinationally and steered to the owner only.
  assign fill     = done && (state == ARB_WAIT_RD);
  assign p0_done  = done && (grant_q == PORT_I);
  assign p1_done  = done && (grant_q == PORT_D);
  assign p0_dout  = (fill && (grant_q == PORT_I)) ? mem_dout : '0;
  assign p1_dout  = (fill && (grant_q == PORT_D)) ? mem_dout : '0;
  assign mem_addr = (state != ARB_IDLE) ? addr_q : '0;
  assign mem_din  = ((state != ARB_IDLE) && rw_q) ? din_q : '0;
  assign grant_id = grant_q;

endmodule
